puzzle_solve_checker: RTL

//  Parametrised, sequential successor to the fixed 3x3 solved-board check.

---
 rtl/puzzle_solve_checker.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/puzzle_solve_checker.sv
// puzzle_solve_checker
// Sequential solved-board checker for an N x N sliding puzzle. A board is
// snapshotted on start, then compared against the goal layout one tile per
// clock. The result (solved flag and misplaced-tile count) is published with a
// one-cycle done pulse, and a sticky game_over flag records that a solved board
// has been seen since it was last cleared.

module puzzle_solve_checker #(
   parameter  int N  = 3,
   parameter  int W  = 4,
   localparam int CW = $clog2(N*N+1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N*N*W-1:0]  board,
   input  logic              start,
   input  logic              mode_blank_first,
   input  logic              clear_over,
   output logic              busy,
   output logic              done,
   output logic              solved,
   output logic [CW-1:0]     misplaced,
   output logic              game_over
);

   localparam int T  = N*N;
   localparam int IW = $clog2(T);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SCAN   = 2'd1;
   localparam logic [1:0] ST_REPORT = 2'd2;

   logic [1:0]      state;
   logic [T*W-1:0]  snap_board;
   logic            snap_mode;
   logic [IW-1:0]   idx;
   logic [CW-1:0]   acc;

   logic [W-1:0]    cur_tile;
   logic [W-1:0]    goal_tile;
   logic            last_tile;
   logic            mismatch;
   logic            acc_zero;

   // Select the snapshot tile at the scan index; tile 0 sits in the MSBs.
   always_comb begin
      cur_tile = '0;
      for (int k = 0; k < T; k++) begin
         if (idx == IW'(k)) begin
            cur_tile = snap_board[(T-k)*W-1 -: W];
         end
      end
   end

   // Goal tile for the scan index and the per-tile mismatch flag. In the
   // blank-last layout tile k holds k+1 and the final position holds the blank;
   // in the blank-first layout tile k simply holds k.
   always_comb begin
      last_tile = (idx == IW'(T-1));
      goal_tile = '0;
      if (snap_mode) begin
         goal_tile = W'(idx);
      end else if (!last_tile) begin
         goal_tile = W'(idx) + W'(1);
      end
      mismatch = (cur_tile != goal_tile);
      acc_zero = (acc == '0);
   end

   // Control FSM plus scan datapath: snapshot on start, walk every tile once,
   // then spend one cycle in REPORT handing the total to the result registers.
   // Starts arriving while a check is in progress are simply dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         snap_board <= '0;
         snap_mode  <= 1'b0;
         idx        <= '0;
         acc        <= '0;
         busy       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  snap_board <= board;
                  snap_mode  <= mode_blank_first;
                  idx        <= '0;
                  acc        <= '0;
                  busy       <= 1'b1;
                  state      <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               acc <= acc + CW'(mismatch);
               if (last_tile) begin
                  state <= ST_REPORT;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            ST_REPORT: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Result registers: solved/misplaced only change when a check finishes, and
   // done pulses for exactly the cycle in which the new result first appears.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done      <= 1'b0;
         solved    <= 1'b0;
         misplaced <= '0;
      end else begin
         done <= 1'b0;
         if (state == ST_REPORT) begin
            done      <= 1'b1;
            solved    <= acc_zero;
            misplaced <= acc;
         end
      end
   end

   // Sticky game_over: a solved report sets it and beats a simultaneous clear;
   // unsolved reports leave it untouched.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         game_over <= 1'b0;
      end else if (state == ST_REPORT && acc_zero) begin
         game_over <= 1'b1;
      end else if (clear_over) begin
         game_over <= 1'b0;
      end
   end

endmodule
